// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - elastic pipeline stage register with two-entry skid buffer,
// flush-to-bubble, sticky halt and saturating flushed-entry counter.
module pipe_stage_reg #(
   parameter int               WIDTH     = 32,
   parameter logic [WIDTH-1:0] NOP_VALUE = '0,
   parameter int               DROP_W    = 8
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  in_data,
   input  logic              in_halt,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  out_data,
   output logic              out_halt,
   input  logic              flush,
   output logic              halted,
   output logic [DROP_W-1:0] drop_cnt
);

   localparam logic [DROP_W+1:0] DROP_MAX = {2'b00, {DROP_W{1'b1}}};

   logic              main_v_q, main_v_d;
   logic [WIDTH-1:0]  main_data_q, main_data_d;
   logic              main_halt_q, main_halt_d;
   logic              skid_v_q, skid_v_d;
   logic [WIDTH-1:0]  skid_data_q, skid_data_d;
   logic              skid_halt_q, skid_halt_d;
   logic              halted_q, halted_d;
   logic [DROP_W-1:0] drop_q, drop_d;

   logic              accept;
   logic              pop;
   logic [1:0]        drop_num;
   logic [DROP_W+1:0] drop_sum;

   // Handshake outputs come from registered state only, so upstream never
   // sees a combinational path from out_ready.
   assign in_ready  = ~skid_v_q & ~halted_q;
   assign out_valid = main_v_q & ~halted_q;
   assign out_data  = out_valid ? main_data_q : NOP_VALUE;
   assign out_halt  = out_valid & main_halt_q;
   assign halted    = halted_q;
   assign drop_cnt  = drop_q;

   assign accept = in_valid & in_ready;
   assign pop    = out_valid & out_ready;

   always_comb begin
      main_v_d    = main_v_q;
      main_data_d = main_data_q;
      main_halt_d = main_halt_q;
      skid_v_d    = skid_v_q;
      skid_data_d = skid_data_q;
      skid_halt_d = skid_halt_q;
      halted_d    = halted_q;
      drop_d      = drop_q;
      drop_num    = 2'd0;
      drop_sum    = '0;

      if (halted_q) begin
         main_v_d = 1'b0;
         skid_v_d = 1'b0;
      end else if (flush) begin
         main_v_d = 1'b0;
         skid_v_d = 1'b0;
         if (pop && main_halt_q) begin
            halted_d = 1'b1;
         end
         drop_num = {1'b0, main_v_q & ~pop} + {1'b0, skid_v_q} + {1'b0, accept};
         drop_sum = {2'b00, drop_q} + {{DROP_W{1'b0}}, drop_num};
         drop_d   = (drop_sum > DROP_MAX) ? {DROP_W{1'b1}} : drop_sum[DROP_W-1:0];
      end else if (pop && main_halt_q) begin
         // The halt marker is the last entry to leave; anything behind it is dead.
         halted_d = 1'b1;
         main_v_d = 1'b0;
         skid_v_d = 1'b0;
      end else if (pop) begin
         if (skid_v_q) begin
            main_v_d    = 1'b1;
            main_data_d = skid_data_q;
            main_halt_d = skid_halt_q;
            skid_v_d    = 1'b0;
         end else begin
            main_v_d    = accept;
            main_data_d = in_data;
            main_halt_d = in_halt;
         end
      end else if (!main_v_q) begin
         main_v_d    = accept;
         main_data_d = in_data;
         main_halt_d = in_halt;
      end else if (accept) begin
         skid_v_d    = 1'b1;
         skid_data_d = in_data;
         skid_halt_d = in_halt;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         main_v_q    <= 1'b0;
         main_data_q <= NOP_VALUE;
         main_halt_q <= 1'b0;
         skid_v_q    <= 1'b0;
         skid_data_q <= NOP_VALUE;
         skid_halt_q <= 1'b0;
         halted_q    <= 1'b0;
         drop_q      <= '0;
      end else begin
         main_v_q    <= main_v_d;
         main_data_q <= main_data_d;
         main_halt_q <= main_halt_d;
         skid_v_q    <= skid_v_d;
         skid_data_q <= skid_data_d;
         skid_halt_q <= skid_halt_d;
         halted_q    <= halted_d;
         drop_q      <= drop_d;
      end
   end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - self-checking bench for pipe_stage_reg: directed scenarios
// plus randomized traffic against a FIFO-of-two reference model.
module tb_pipe_stage_reg;

   localparam int          W   = 32;
   localparam int          DW  = 2;
   localparam logic [31:0] NOP = 32'hDEAD_BEEF;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  in_data = '0;
   logic          in_halt = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [W-1:0]  out_data;
   logic          out_halt;
   logic          flush = 1'b0;
   logic          halted;
   logic [DW-1:0] drop_cnt;

   int total = 0;
   int bad   = 0;

   pipe_stage_reg #(.WIDTH(W), .NOP_VALUE(NOP), .DROP_W(DW)) dut (
      .CLK(CLK), .RST(RST),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_halt(in_halt),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_halt(out_halt),
      .flush(flush), .halted(halted), .drop_cnt(drop_cnt)
   );

   always #5 CLK = ~CLK;

   task automatic drive(input logic v, input logic [W-1:0] d, input logic h,
                        input logic r, input logic f);
      in_valid  = v;
      in_data   = d;
      in_halt   = h;
      out_ready = r;
      flush     = f;
   endtask

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset;
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
      RST = 1'b1;
      tick();
      RST = 1'b0;
   endtask

   task automatic test_reset;
      do_reset();
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      total++; if (out_data !== NOP) begin bad++; $display("FAIL reset_out_data: got %h want %h", out_data, NOP); end
      total++; if (out_halt !== 1'b0) begin bad++; $display("FAIL reset_out_halt: got %b want 0", out_halt); end
      total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted: got %b want 0", halted); end
      total++; if (drop_cnt !== 2'd0) begin bad++; $display("FAIL reset_drop_cnt: got %0d want 0", drop_cnt); end
      // Asynchronous reset must clear a held entry without waiting for an edge.
      drive(1'b1, 32'h55, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
      #2 RST = 1'b1;
      #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL async_reset_out_valid: got %b want 0", out_valid); end
      @(posedge CLK);
      #1 RST = 1'b0;
   endtask

   task automatic test_stream;
      do_reset();
      for (int i = 1; i <= 8; i++) begin
         drive(1'b1, W'(i), 1'b0, 1'b1, 1'b0);
         tick();
         total++;
         if (out_valid !== 1'b1 || out_data !== W'(i) || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL stream_%0d: got v=%b d=%h rdy=%b want v=1 d=%h rdy=1",
                     i, out_valid, out_data, in_ready, W'(i));
         end
      end
      drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_drain: got %b want 0", out_valid); end
   endtask

   task automatic test_backpressure;
      do_reset();
      drive(1'b1, 32'hA, 1'b0, 1'b1, 1'b0);
      tick();
      drive(1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
      tick();
      total++;
      if (out_data !== 32'hA || in_ready !== 1'b0) begin
         bad++; $display("FAIL bp_full: got d=%h rdy=%b want d=a rdy=0", out_data, in_ready);
      end
      drive(1'b1, 32'hC, 1'b0, 1'b0, 1'b0);
      tick();
      total++;
      if (out_data !== 32'hA || in_ready !== 1'b0) begin
         bad++; $display("FAIL bp_hold: got d=%h rdy=%b want d=a rdy=0", out_data, in_ready);
      end
      drive(1'b1, 32'hC, 1'b0, 1'b1, 1'b0);
      tick();
      total++;
      if (out_valid !== 1'b1 || out_data !== 32'hB || in_ready !== 1'b1) begin
         bad++; $display("FAIL bp_drain_b: got v=%b d=%h rdy=%b want v=1 d=b rdy=1", out_valid, out_data, in_ready);
      end
      tick();
      total++;
      if (out_valid !== 1'b1 || out_data !== 32'hC) begin
         bad++; $display("FAIL bp_drain_c: got v=%b d=%h want v=1 d=c", out_valid, out_data);
      end
      drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_empty: got %b want 0", out_valid); end
   endtask

   task automatic test_flush_full;
      do_reset();
      drive(1'b1, 32'h10, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b1, 32'h11, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b1, 32'h12, 1'b0, 1'b0, 1'b1);
      tick();
      total++;
      if (out_valid !== 1'b0 || out_data !== NOP || drop_cnt !== 2'd2) begin
         bad++; $display("FAIL flush_full: got v=%b d=%h drop=%0d want v=0 d=%h drop=2", out_valid, out_data, drop_cnt, NOP);
      end
      drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_full_noaccept: got %b want 0", out_valid); end
   endtask

   task automatic test_flush_pop;
      do_reset();
      drive(1'b1, 32'h20, 1'b0, 1'b1, 1'b0);
      tick();
      drive(1'b1, 32'h21, 1'b0, 1'b1, 1'b1);
      #1;
      total++;
      if (out_valid !== 1'b1 || out_data !== 32'h20) begin
         bad++; $display("FAIL flush_pop_deliver: got v=%b d=%h want v=1 d=20", out_valid, out_data);
      end
      tick();
      total++;
      if (out_valid !== 1'b0 || drop_cnt !== 2'd1) begin
         bad++; $display("FAIL flush_pop: got v=%b drop=%0d want v=0 drop=1", out_valid, drop_cnt);
      end
   endtask

   task automatic test_halt;
      do_reset();
      drive(1'b1, 32'h30, 1'b0, 1'b1, 1'b0);
      tick();
      drive(1'b1, 32'h31, 1'b1, 1'b1, 1'b0);
      tick();
      total++;
      if (out_data !== 32'h31 || out_halt !== 1'b1) begin
         bad++; $display("FAIL halt_present: got d=%h h=%b want d=31 h=1", out_data, out_halt);
      end
      drive(1'b1, 32'h32, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         total++;
         if (halted !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== NOP) begin
            bad++; $display("FAIL halt_sticky_%0d: got hl=%b rdy=%b v=%b d=%h want hl=1 rdy=0 v=0 d=%h",
                            i, halted, in_ready, out_valid, out_data, NOP);
         end
      end
      do_reset();
      total++;
      if (halted !== 1'b0 || in_ready !== 1'b1) begin
         bad++; $display("FAIL halt_reset: got hl=%b rdy=%b want hl=0 rdy=1", halted, in_ready);
      end
   endtask

   task automatic test_saturation;
      logic [DW-1:0] want [3];
      want[0] = 2'd2; want[1] = 2'd3; want[2] = 2'd3;
      do_reset();
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, W'(32'h40 + 2 * k), 1'b0, 1'b0, 1'b0);
         tick();
         drive(1'b1, W'(32'h41 + 2 * k), 1'b0, 1'b0, 1'b0);
         tick();
         drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
         tick();
         total++;
         if (drop_cnt !== want[k]) begin
            bad++; $display("FAIL saturate_%0d: got %0d want %0d", k, drop_cnt, want[k]);
         end
      end
   endtask

   task automatic test_random;
      logic [W-1:0] qd[$];
      logic         qh[$];
      int           m_drop;
      bit           m_halt;
      int           halt_age;
      bit           exp_rdy, exp_v, exp_h, acc, pp;
      logic [W-1:0] exp_d;
      do_reset();
      m_drop = 0; m_halt = 0; halt_age = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         drive(($urandom_range(3) != 0), $urandom, ($urandom_range(39) == 0),
               ($urandom_range(2) != 0), ($urandom_range(24) == 0));
         #1;
         exp_rdy = (qd.size() < 2) && !m_halt;
         exp_v   = (qd.size() > 0) && !m_halt;
         exp_d   = exp_v ? qd[0] : NOP;
         exp_h   = exp_v ? qh[0] : 1'b0;
         total++;
         if ({in_ready, out_valid, out_data, out_halt, halted} !== {exp_rdy, exp_v, exp_d, exp_h, m_halt}) begin
            bad++;
            $display("FAIL random_%0d: got rdy=%b v=%b d=%h h=%b hl=%b want rdy=%b v=%b d=%h h=%b hl=%b",
                     cyc, in_ready, out_valid, out_data, out_halt, halted,
                     exp_rdy, exp_v, exp_d, exp_h, m_halt);
         end
         total++;
         if (drop_cnt !== DW'(m_drop)) begin
            bad++; $display("FAIL random_drop_%0d: got %0d want %0d", cyc, drop_cnt, m_drop);
         end
         acc = in_valid && exp_rdy;
         pp  = exp_v && out_ready;
         tick();
         if (pp) begin
            if (qh[0]) m_halt = 1;
            void'(qd.pop_front());
            void'(qh.pop_front());
         end
         if (flush) begin
            m_drop = m_drop + qd.size() + int'(acc);
            if (m_drop > 3) m_drop = 3;
            qd.delete(); qh.delete();
         end else if (m_halt) begin
            qd.delete(); qh.delete();
         end else if (acc) begin
            qd.push_back(in_data);
            qh.push_back(in_halt);
         end
         if (m_halt) halt_age++;
         if (halt_age > 3) begin
            do_reset();
            qd.delete(); qh.delete();
            m_drop = 0; m_halt = 0; halt_age = 0;
         end
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_flush_full();
      test_flush_pop();
      test_halt();
      test_saturation();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
